// File: rtl/final_vending.sv
// final_vending: coin-operated vending block.
// Accumulates inserted money into a saturating 8-bit balance and a 3-bit
// item quantity. A checkout either sells (price x quantity) and returns the
// change, or refunds the full balance. Balance and charge are shown on two
// 3-digit active-high 7-segment displays (bit0=a .. bit6=g).
module final_vending (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  number,
  input  logic [1:0]  sel,
  input  logic [2:0]  sel_type,
  output logic        if_sell,
  output logic [2:0]  out_type,
  output logic [7:0]  charge,
  output logic [20:0] seven_all,
  output logic [20:0] seven_char
);

  // One operation per cycle, selected directly by sel.
  typedef enum logic [1:0] {
    OP_INSERT   = 2'b00,
    OP_ADD      = 2'b01,
    OP_REMOVE   = 2'b10,
    OP_CHECKOUT = 2'b11
  } op_t;

  localparam logic [7:0] BAL_MAX = 8'd255;
  localparam logic [2:0] QTY_MAX = 3'd7;

  // Architectural state
  logic [7:0] balance;
  logic [2:0] qty;

  // Next-state values
  logic [7:0] balance_nxt;
  logic [2:0] qty_nxt;
  logic       if_sell_nxt;
  logic [2:0] out_type_nxt;
  logic [7:0] charge_nxt;

  // Checkout arithmetic
  op_t        op;
  logic [8:0] sum_wide;
  logic [7:0] unit_price;
  logic       type_valid;
  logic [2:0] eff_qty;
  logic [7:0] cost;
  logic       can_pay;

  // Unit price per product; 0 for the invalid selectors 0 and 7.
  function automatic logic [7:0] price_of(input logic [2:0] t);
    logic [7:0] p;
    case (t)
      3'd1:    p = 8'd10;
      3'd2:    p = 8'd15;
      3'd3:    p = 8'd20;
      3'd4:    p = 8'd25;
      3'd5:    p = 8'd30;
      3'd6:    p = 8'd35;
      default: p = 8'd0;
    endcase
    return p;
  endfunction

  // Binary (0..255) to three BCD digits {hundreds, tens, ones}, using
  // compare-and-subtract so no general divider is built.
  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    logic [7:0] r;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    r = v;
    h = 4'd0;
    if (r >= 8'd200) begin
      h = 4'd2;
      r = r - 8'd200;
    end else if (r >= 8'd100) begin
      h = 4'd1;
      r = r - 8'd100;
    end
    t = 4'd0;
    for (int k = 1; k < 10; k++) begin
      if (r >= 8'(k * 10)) t = 4'(k);
    end
    o = 4'(r - (8'(t) * 8'd10));
    return {h, t, o};
  endfunction

  // Decimal digit to segment pattern; out-of-range digits blank.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Three digits rendered as {hundreds, tens, ones} segment groups.
  function automatic logic [20:0] display_of(input logic [7:0] v);
    logic [11:0] bcd;
    bcd = to_bcd(v);
    return {seg_of(bcd[11:8]), seg_of(bcd[7:4]), seg_of(bcd[3:0])};
  endfunction

  assign op = op_t'(sel);

  // Checkout cost: a checkout with qty 0 still buys one item.
  always_comb begin
    sum_wide   = {1'b0, balance} + {1'b0, number};
    unit_price = price_of(sel_type);
    type_valid = (sel_type != 3'd0) && (sel_type != 3'd7);
    eff_qty    = (qty == 3'd0) ? 3'd1 : qty;
    cost       = unit_price * {5'd0, eff_qty};
    can_pay    = type_valid && (balance >= cost);
  end

  // Next balance/qty and the one-cycle checkout result.
  always_comb begin
    balance_nxt  = balance;
    qty_nxt      = qty;
    if_sell_nxt  = 1'b0;
    out_type_nxt = 3'd0;
    charge_nxt   = 8'd0;
    case (op)
      OP_INSERT: begin
        balance_nxt = sum_wide[8] ? BAL_MAX : sum_wide[7:0];
      end
      OP_ADD: begin
        if (qty != QTY_MAX) qty_nxt = qty + 3'd1;
      end
      OP_REMOVE: begin
        if (qty != 3'd0) qty_nxt = qty - 3'd1;
      end
      OP_CHECKOUT: begin
        balance_nxt = 8'd0;
        qty_nxt     = 3'd0;
        if (can_pay) begin
          if_sell_nxt  = 1'b1;
          out_type_nxt = sel_type;
          charge_nxt   = balance - cost;
        end else begin
          charge_nxt   = balance;
        end
      end
      default: begin
        balance_nxt = balance;
      end
    endcase
  end

  // State and result registers; reset drops everything with no refund.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      balance  <= 8'd0;
      qty      <= 3'd0;
      if_sell  <= 1'b0;
      out_type <= 3'd0;
      charge   <= 8'd0;
    end else begin
      balance  <= balance_nxt;
      qty      <= qty_nxt;
      if_sell  <= if_sell_nxt;
      out_type <= out_type_nxt;
      charge   <= charge_nxt;
    end
  end

  // Displays follow the registered values combinationally.
  always_comb begin
    seven_all  = display_of(balance);
    seven_char = display_of(charge);
  end

endmodule

// File: tb/tb_final_vending.sv
// Testbench for final_vending: directed scenarios followed by random
// operations, all checked against a behavioural model of the vending rules.
module tb_final_vending;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic [7:0]  number;
  logic [1:0]  sel;
  logic [2:0]  sel_type;
  logic        if_sell;
  logic [2:0]  out_type;
  logic [7:0]  charge;
  logic [20:0] seven_all;
  logic [20:0] seven_char;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  final_vending dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .number     (number),
    .sel        (sel),
    .sel_type   (sel_type),
    .if_sell    (if_sell),
    .out_type   (out_type),
    .charge     (charge),
    .seven_all  (seven_all),
    .seven_char (seven_char)
  );

  // ---------------- reference model ----------------
  int checks = 0;
  int errors = 0;

  int m_balance;
  int m_qty;
  int m_if_sell;
  int m_out_type;
  int m_charge;

  int price_tab[8] = '{0, 10, 15, 20, 25, 30, 35, 0};
  logic [6:0] seg_tab[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [20:0] exp_disp(input int v);
    return {seg_tab[v / 100], seg_tab[(v / 10) % 10], seg_tab[v % 10]};
  endfunction

  task automatic model_reset();
    m_balance  = 0;
    m_qty      = 0;
    m_if_sell  = 0;
    m_out_type = 0;
    m_charge   = 0;
  endtask

  // Apply one operation to the model using plain arithmetic.
  task automatic model_op(input int s, input int n, input int t);
    int cost;
    m_if_sell  = 0;
    m_out_type = 0;
    m_charge   = 0;
    case (s)
      0: m_balance = (m_balance + n > 255) ? 255 : m_balance + n;
      1: m_qty = (m_qty < 7) ? m_qty + 1 : 7;
      2: m_qty = (m_qty > 0) ? m_qty - 1 : 0;
      default: begin
        cost = price_tab[t] * ((m_qty > 1) ? m_qty : 1);
        if (t >= 1 && t <= 6 && m_balance >= cost) begin
          m_if_sell  = 1;
          m_out_type = t;
          m_charge   = m_balance - cost;
        end else begin
          m_charge   = m_balance;
        end
        m_balance = 0;
        m_qty     = 0;
      end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".if_sell"},    32'(if_sell),    32'(m_if_sell));
    check({tag, ".out_type"},   32'(out_type),   32'(m_out_type));
    check({tag, ".charge"},     32'(charge),     32'(m_charge));
    check({tag, ".seven_all"},  32'(seven_all),  32'(exp_disp(m_balance)));
    check({tag, ".seven_char"}, 32'(seven_char), 32'(exp_disp(m_charge)));
  endtask

  // ---------------- driver ----------------
  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic do_op(input int s, input int n, input int t, input string tag);
    @(negedge clk);
    sel      = 2'(s);
    number   = 8'(n);
    sel_type = 3'(t);
    @(posedge clk);
    #1;
    model_op(s, n, t);
    check_all(tag);
  endtask

  task automatic insert(input int n, input int t);
    do_op(0, n, t, "insert");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    number   = 8'd0;
    sel      = 2'd0;
    sel_type = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset.seven_all", 32'(seven_all), 32'h0FDFBF);
    @(negedge clk);
    rst_n = 1'b1;

    // sel_type 1: 20 + 60 + 70 = 150, one item at 10 -> change 140
    insert(20, 3);
    do_op(1, 0, 5, "add");
    insert(60, 0);
    insert(70, 7);
    do_op(3, 0, 1, "co_t1");
    check("t1.charge", 32'(charge), 32'd140);
    check("t1.if_sell", 32'(if_sell), 32'd1);
    check("t1.out_type", 32'(out_type), 32'd1);
    do_op(0, 0, 1, "idle_after_t1");

    // sel_type 6: three items cost 105 > 80 -> refund 80
    repeat (3) do_op(1, 0, 6, "add");
    insert(80, 6);
    do_op(3, 0, 6, "co_t6");
    check("t6.charge", 32'(charge), 32'd80);
    check("t6.if_sell", 32'(if_sell), 32'd0);

    // sel_type 2: qty 2-1=1, balance 25, cost 15 -> change 10
    do_op(1, 0, 2, "add");
    do_op(1, 0, 2, "add");
    do_op(2, 99, 2, "remove");
    insert(5, 2);
    insert(20, 2);
    do_op(3, 0, 2, "co_t2");
    check("t2.charge", 32'(charge), 32'd10);
    check("t2.out_type", 32'(out_type), 32'd2);

    // Saturation: balance 255, then 8 adds -> qty 7, 7*10=70 -> change 185
    insert(200, 0);
    insert(100, 0);
    check("sat.seven_all", 32'(seven_all), {11'd0, 7'h5B, 7'h6D, 7'h6D});
    repeat (8) do_op(1, 0, 0, "add_sat");
    do_op(3, 0, 1, "co_sat");
    check("sat.charge", 32'(charge), 32'd185);

    // Remove below zero, then checkout at qty 0 buys one item
    insert(40, 0);
    repeat (2) do_op(2, 0, 0, "remove_floor");
    do_op(3, 0, 4, "co_floor");
    check("floor.charge", 32'(charge), 32'd15);

    // Invalid type 7: full refund, then idle clears
    insert(50, 7);
    do_op(3, 0, 7, "co_t7");
    check("t7.charge", 32'(charge), 32'd50);
    do_op(0, 0, 7, "idle_after_t7");
    check("t7.idle_charge", 32'(charge), 32'd0);
    check("t7.idle_bal", 32'(seven_all), 32'(exp_disp(0)));

    // Async reset between edges: immediate clear, no refund afterwards
    insert(80, 1);
    @(negedge clk);
    sel    = 2'd0;
    number = 8'd0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    rst_n = 1'b1;
    do_op(3, 0, 1, "co_after_rst");
    check("rst.charge", 32'(charge), 32'd0);

    // Random operations; checkout less frequent so balances build up
    for (int i = 0; i < 400; i++) begin
      int r;
      int s;
      r = $urandom_range(0, 9);
      s = (r < 5) ? 0 : (r < 7) ? 1 : (r < 8) ? 2 : 3;
      do_op(s, $urandom_range(0, 90), $urandom_range(0, 7), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/final_vending.md
FINAL_VENDING -- requirements
Module: final_vending

Interface
REQ-001 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 number  input  8  unsigned coin/amount value; used only when sel=00.
REQ-004 sel  input  2  operation per cycle: 00 insert, 01 add item, 10 remove item, 11 checkout.
REQ-005 sel_type  input  3  product selector; valid products 1..6; 0 and 7 invalid.
REQ-006 if_sell  output  1  registered; 1 for one cycle after a successful checkout.
REQ-007 out_type  output  3  registered; product dispensed, valid with if_sell.
REQ-008 charge  output  8  registered; change/refund amount, one cycle after checkout.
REQ-009 seven_all  output  21  3-digit 7-segment display of current balance.
REQ-010 seven_char  output  21  3-digit 7-segment display of charge.

Function
REQ-011 The block SHALL hold state registers balance (8 bit) and qty (3 bit); every operation is sampled once per rising edge, one operation per cycle.
REQ-012 sel=00 SHALL set balance = balance + number, saturating at 255; number=0 with sel=00 is the idle/no-op cycle.
REQ-013 sel=01 SHALL increment qty, saturating at 7; balance unchanged.
REQ-014 sel=10 SHALL decrement qty, saturating at 0; number ignored; balance unchanged.
REQ-015 Unit price by sel_type SHALL be: 1=10, 2=15, 3=20, 4=25, 5=30, 6=35.
REQ-016 At checkout (sel=11), effective quantity SHALL be max(qty,1); cost = price x effective quantity (max 245, fits 8 bits).
REQ-017 Checkout with valid sel_type and balance >= cost SHALL set if_sell=1, out_type=sel_type, charge=balance-cost on the next edge.
REQ-018 Checkout with balance < cost, or sel_type 0/7, SHALL set if_sell=0, out_type=0, charge=balance (full refund).
REQ-019 Every checkout SHALL clear balance and qty to 0 on the same edge.
REQ-020 On any non-checkout cycle if_sell, out_type and charge SHALL be 0 on the next edge (single-cycle pulse).
REQ-021 sel_type SHALL be sampled only at checkout; changing it earlier has no effect.
REQ-022 Displays SHALL be combinational from registered balance (seven_all) and charge (seven_char): decimal digits hundreds [20:14], tens [13:7], ones [6:0].
REQ-023 Segment code per digit (bit0=a..bit6=g, active-high): 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex); leading zeros displayed.

Reset
REQ-024 rst_n low SHALL immediately clear balance, qty, if_sell, out_type, charge to 0 without waiting for clk; seven_all and seven_char then show 3F/3F/3F.
REQ-025 Reset asserted mid-transaction SHALL discard balance and qty with no refund output; first operation after rst_n rises is processed normally on the next edge.

Verification
REQ-026 sel_type=1: insert 20, sel=01, insert 60, insert 70, checkout -> if_sell=1, out_type=1, charge=140 (150-10).
REQ-027 sel_type=6: sel=01 three times, insert 80, checkout -> cost 105 > 80 -> if_sell=0, out_type=0, charge=80.
REQ-028 sel_type=2: sel=01 twice, sel=10 once, insert 5, insert 20, checkout -> if_sell=1, out_type=2, charge=10.
REQ-029 Saturation: insert 200, insert 100 -> balance 255, seven_all digits 2/5/5 (5B/6D/6D); sel=01 eight times -> qty 7.
REQ-030 sel_type=7, insert 50, checkout -> if_sell=0, charge=50; following idle cycle -> charge=0, balance=0.
REQ-031 Insert 80, assert rst_n low between edges -> balance 0 and outputs 0 immediately; checkout after release -> charge=0.
